spi_regif: RTL
==============

// Module: spi_regif
// PURPOSE
//  SPI mode-0 slave register interface: host side of the motor control register file.
//  Decodes 16-bit SPI frames into wrtdata plus one-clk load strobes (ctrlld, cfgld0-2, wdogdivld),
//  returns readback bytes on MISO, and issues the watchdog kick (wdreset).
//  Sits between the board SPI pins and the control block.
// PARAMETERS
//  SYNC_STAGES  2      flops in each pin synchronizer (sclk, cs_n, mosi); legal values 2..3
//  HWCFG_ADDR   7'h0F  read-only address of hwconfig
// PORTS
//  clk           in   1  system clock; single clock domain
//  reset         in   1  asynchronous, active-high reset
//  sclk          in   1  SPI clock, async to clk, f(sclk) <= f(clk)/8
//  cs_n          in   1  SPI chip select, active low, async
//  mosi          in   1  SPI data in, MSB first
//  miso          out  1  SPI data out, MSB first
//  miso_oe       out  1  MISO output enable (1 while synced cs_n low)
//  wrtdata       out  8  write data to register file; held until next write
//  ctrlld        out  1  1-clk load strobe, addr 0x00
//  cfgld0        out  1  1-clk load strobe, addr 0x01
//  cfgld1        out  1  1-clk load strobe, addr 0x02
//  cfgld2        out  1  1-clk load strobe, addr 0x03
//  wdogdivld     out  1  1-clk load strobe, addr 0x04
//  wdreset       out  1  1-clk watchdog kick pulse
//  controlrdata  in   8  readback, addr 0x00
//  configrdreg0  in   8  readback, addr 0x01
//  configrdreg1  in   8  readback, addr 0x02
//  configrdreg2  in   8  readback, addr 0x03
//  hwconfig      in   8  readback, addr HWCFG_ADDR
// BEHAVIOUR
//  Reset: all outputs 0 (miso=0, miso_oe=0, wrtdata=8'h00, all strobes 0); FSM -> IDLE; bit counter 0.
//  Frame: byte0 = {rw, addr[6:0]}, rw=1 write, rw=0 read. byte1 = write data from MOSI or read data to MISO.
//  Bit timing: MOSI sampled on synced sclk rise. MISO updated on synced sclk fall.
//  FSM states and transitions:
//   IDLE  -> ADDR on cs_n fall.
//   ADDR  -> DATA after 8th rise. At that transition, latch the read byte into the tx shifter.
//            First fall after that drives bit 7 on MISO.
//   DATA  -> DONE after 16th rise.
//   DONE: ignore further sclk edges; -> IDLE on cs_n rise.
//  Write commit: registered 1 clk after the 16th rise is detected.
//   wrtdata <= rx byte and the decoded strobe =1, both in the same clk.
//   Strobe width is exactly 1 clk.
//  Read map: 0x00..0x03 as listed in PORTS; 0x04 reads 8'h00 (write-only); HWCFG_ADDR reads hwconfig.
//   All other addresses read 8'h00.
//  Unmapped write or write to HWCFG_ADDR: no strobe asserted, wrtdata unchanged.
//  cs_n rise before the 16th rise (abort): FSM -> IDLE, no strobe, no wdreset, wrtdata unchanged.
//  cs_n rise and sclk edge in the same clk: cs_n wins.
//  miso_oe follows synced ~cs_n. MISO reads 0 in IDLE and DONE.
//  Reset asserted mid-frame: immediate return to the reset state. The next frame needs a fresh cs_n fall.
// CONFIGURATION
//  REGIF_WDKICK_ANY_EN defined:
//   wdreset pulses 1 clk after ANY completed frame (read, write, or unmapped), same cycle as the commit.
//  REGIF_WDKICK_ANY_EN undefined:
//   wdreset pulses only with ctrlld (completed write to addr 0x00).
// STRUCTURE
//  Package regif_pkg:
//   address constants (REGIF_ADDR_CTRL=7'h00, _CFG0..2=7'h01..03, _WDOGDIV=7'h04)
//   FSM state encoding {IDLE, ADDR, DATA, DONE}
//   FRAME_BITS=16
//  Sub-module sync_edge: SYNC_STAGES synchronizer plus rise/fall pulse outputs.
//   One instance each for sclk and cs_n. mosi uses synchronizer only.
// TESTING
//  Write frame 0x80,0x88 (sclk = clk/8) -> ctrlld 1-clk pulse, wrtdata=8'h88, wdreset pulse both macro settings.
//  configrdreg0=8'h35, read frame 0x01,0x00 -> MISO byte1 = 0x35 MSB first, no strobes;
//   wdreset pulses only with REGIF_WDKICK_ANY_EN.
//  Write 0x84,0x40 -> wdogdivld pulse, wrtdata=8'h40.
//   Then read 0x04 -> MISO 0x00. Then read HWCFG_ADDR with hwconfig=8'h30 -> MISO 0x30.
//  Write frame aborted after 10 bits (cs_n high) -> no strobe, no wdreset, wrtdata holds 8'h40.
//   Next full frame decodes normally.
//  Write 0xA0,0xFF (unmapped) and 0x8F,0x12 -> no strobes, wrtdata unchanged.
//  20 sclk pulses in one cs_n window, write 0x81,0x5A -> exactly one cfgld0 pulse, wrtdata=8'h5A, trailing bits ignored.
//  reset pulse at bit 12 of a write -> all outputs 0, no strobe.
//   Following frame 0x82,0x77 -> cfgld1, wrtdata=8'h77.

Source files
------------

// File: rtl/regif_pkg.sv
// rtl/regif_pkg.sv - shared constants and FSM encoding for the SPI register interface
// Purpose: register address map, frame length and frame-FSM state type used by spi_regif.
// Ports: none (package).
package regif_pkg;

  localparam logic [6:0] REGIF_ADDR_CTRL    = 7'h00;
  localparam logic [6:0] REGIF_ADDR_CFG0    = 7'h01;
  localparam logic [6:0] REGIF_ADDR_CFG1    = 7'h02;
  localparam logic [6:0] REGIF_ADDR_CFG2    = 7'h03;
  localparam logic [6:0] REGIF_ADDR_WDOGDIV = 7'h04;

  localparam int FRAME_BITS = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2,
    DONE = 2'd3
  } regif_state_t;

endpackage

// File: rtl/sync_edge.sv
// rtl/sync_edge.sv - multi-flop pin synchronizer with rise/fall pulse outputs
// Purpose: brings an asynchronous pin into the clk domain and flags its edges.
// Ports:
//   clk, reset  system clock, asynchronous active-high reset
//   din         asynchronous input pin
//   sync        synchronized level
//   rise, fall  1-clk pulses on synchronized rising / falling edge
module sync_edge #(
  parameter int   STAGES    = 2,
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic sync,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] chain;
  logic              last;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      chain <= {STAGES{RESET_VAL}};
      last  <= RESET_VAL;
    end else begin
      chain <= {chain[STAGES-2:0], din};
      last  <= chain[STAGES-1];
    end
  end

  assign sync = chain[STAGES-1];
  assign rise = sync & ~last;
  assign fall = ~sync & last;

endmodule

// File: rtl/spi_regif.sv
// rtl/spi_regif.sv - SPI mode-0 slave front end of the motor control register file
// Purpose: decodes 16-bit frames {rw, addr[6:0]}, {data} into write data plus 1-clk
//   load strobes, shifts readback bytes out on MISO and issues the watchdog kick.
// Optional feature: define REGIF_WDKICK_ANY_EN to kick the watchdog on every completed
//   frame; otherwise the kick accompanies ctrlld only.
// Ports:
//   clk, reset               system clock, asynchronous active-high reset
//   sclk, cs_n, mosi         SPI pins (asynchronous)
//   miso, miso_oe            SPI data out and its output enable
//   wrtdata                  write data, held until the next mapped write
//   ctrlld, cfgld0..2,
//   wdogdivld                1-clk load strobes for addresses 0x00..0x04
//   wdreset                  1-clk watchdog kick
//   controlrdata, configrdreg0..2, hwconfig   readback sources
module spi_regif
  import regif_pkg::*;
#(
  parameter int         SYNC_STAGES = 2,
  parameter logic [6:0] HWCFG_ADDR  = 7'h0F
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       sclk,
  input  logic       cs_n,
  input  logic       mosi,
  output logic       miso,
  output logic       miso_oe,
  output logic [7:0] wrtdata,
  output logic       ctrlld,
  output logic       cfgld0,
  output logic       cfgld1,
  output logic       cfgld2,
  output logic       wdogdivld,
  output logic       wdreset,
  input  logic [7:0] controlrdata,
  input  logic [7:0] configrdreg0,
  input  logic [7:0] configrdreg1,
  input  logic [7:0] configrdreg2,
  input  logic [7:0] hwconfig
);

  localparam logic [4:0] LAST_ADDR_BIT = 5'(FRAME_BITS / 2 - 1);
  localparam logic [4:0] LAST_BIT      = 5'(FRAME_BITS - 1);

  regif_state_t state, state_nxt;

  logic sclk_sync_unused, sclk_rise, sclk_fall;
  logic cs_sync, cs_rise, cs_fall;
  logic [SYNC_STAGES-1:0] mosi_pipe;
  logic mosi_s;

  logic [4:0]            bitcnt;
  logic [FRAME_BITS-2:0] rx;
  logic [7:0]            tx;
  logic [7:0]            rd_byte;
  logic [6:0]            rd_addr, wr_addr;
  logic [4:0]            wr_hit;
  logic                  commit;

  sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sclk_sync (
    .clk(clk), .reset(reset), .din(sclk),
    .sync(sclk_sync_unused), .rise(sclk_rise), .fall(sclk_fall)
  );

  // cs_n resets to "selected": a frame already in progress when reset releases
  // produces no falling edge, so only a fresh cs_n fall can start a frame.
  sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_cs_sync (
    .clk(clk), .reset(reset), .din(cs_n),
    .sync(cs_sync), .rise(cs_rise), .fall(cs_fall)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) mosi_pipe <= '0;
    else       mosi_pipe <= {mosi_pipe[SYNC_STAGES-2:0], mosi};
  end
  assign mosi_s = mosi_pipe[SYNC_STAGES-1];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // cs_n rise is checked first everywhere, so it wins over a same-clk sclk edge.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (cs_fall) state_nxt = ADDR;
      ADDR: if (cs_rise) state_nxt = IDLE;
            else if (sclk_rise && bitcnt == LAST_ADDR_BIT) state_nxt = DATA;
      DATA: if (cs_rise) state_nxt = IDLE;
            else if (sclk_rise && bitcnt == LAST_BIT) state_nxt = DONE;
      DONE: if (cs_rise) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Address completes with the bit arriving on the 8th rise.
  assign rd_addr = {rx[5:0], mosi_s};

  always_comb begin
    rd_byte = 8'h00;
    if (rd_addr == HWCFG_ADDR) rd_byte = hwconfig;
    else begin
      case (rd_addr)
        REGIF_ADDR_CTRL: rd_byte = controlrdata;
        REGIF_ADDR_CFG0: rd_byte = configrdreg0;
        REGIF_ADDR_CFG1: rd_byte = configrdreg1;
        REGIF_ADDR_CFG2: rd_byte = configrdreg2;
        default:         rd_byte = 8'h00;
      endcase
    end
  end

  // At the 16th rise rx holds bits 0..14: rw in rx[14], address in rx[13:7].
  assign wr_addr = rx[13:7];
  assign commit  = (state == DATA) && sclk_rise && !cs_rise && (bitcnt == LAST_BIT);

  always_comb begin
    wr_hit = 5'b0;
    if (rx[14] && wr_addr != HWCFG_ADDR) begin
      case (wr_addr)
        REGIF_ADDR_CTRL:    wr_hit[0] = 1'b1;
        REGIF_ADDR_CFG0:    wr_hit[1] = 1'b1;
        REGIF_ADDR_CFG1:    wr_hit[2] = 1'b1;
        REGIF_ADDR_CFG2:    wr_hit[3] = 1'b1;
        REGIF_ADDR_WDOGDIV: wr_hit[4] = 1'b1;
        default:            wr_hit = 5'b0;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bitcnt    <= '0;
      rx        <= '0;
      tx        <= '0;
      miso      <= 1'b0;
      miso_oe   <= 1'b0;
      wrtdata   <= 8'h00;
      ctrlld    <= 1'b0;
      cfgld0    <= 1'b0;
      cfgld1    <= 1'b0;
      cfgld2    <= 1'b0;
      wdogdivld <= 1'b0;
      wdreset   <= 1'b0;
    end else begin
      miso_oe   <= ~cs_sync;
      ctrlld    <= commit & wr_hit[0];
      cfgld0    <= commit & wr_hit[1];
      cfgld1    <= commit & wr_hit[2];
      cfgld2    <= commit & wr_hit[3];
      wdogdivld <= commit & wr_hit[4];
`ifdef REGIF_WDKICK_ANY_EN
      wdreset   <= commit;
`else
      wdreset   <= commit & wr_hit[0];
`endif
      if (commit && |wr_hit) wrtdata <= {rx[6:0], mosi_s};

      case (state)
        IDLE: begin
          miso <= 1'b0;
          if (cs_fall) bitcnt <= '0;
        end
        ADDR: begin
          miso <= 1'b0;
          if (!cs_rise && sclk_rise) begin
            rx     <= {rx[FRAME_BITS-3:0], mosi_s};
            bitcnt <= bitcnt + 5'd1;
            if (bitcnt == LAST_ADDR_BIT) tx <= rd_byte;
          end
        end
        DATA: begin
          if (cs_rise) miso <= 1'b0;
          else if (sclk_rise) begin
            rx     <= {rx[FRAME_BITS-3:0], mosi_s};
            bitcnt <= bitcnt + 5'd1;
            if (bitcnt == LAST_BIT) miso <= 1'b0;
          end else if (sclk_fall) begin
            miso <= tx[7];
            tx   <= {tx[6:0], 1'b0};
          end
        end
        default: miso <= 1'b0;
      endcase
    end
  end

endmodule
